// File: rtl/avalon_muldiv_seq.sv
// avalon_muldiv_seq
//   Multi-cycle signed/unsigned multiplier and divider behind an Avalon-MM
//   slave port. The CPU loads OPA/OPB and then writes CTRL with start=1. The
//   core takes absolute values, runs WIDTH shift-add or restoring
//   shift-subtract steps, applies the sign correction and then raises done.
//
//   Register map (address):
//     0 OPA    RW
//     1 OPB    RW
//     2 CTRL   W: b0 start, b1 op (0 mul, 1 div), b2 signed, b3 ie
//              R: {ie, signed, op, 0}
//     3 STAT   R: b0 busy, b1 done, b2 dz   W: b1=1 clears done and dz
//     4 RES_LO product[W-1:0] or quotient
//     5 RES_HI product[2W-1:W] or remainder
//     6,7      read 0
//
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     address           register index
//     writedata/write   write data and strobe (qualified by chipselect)
//     read              read strobe (qualified by chipselect)
//     chipselect        slave select
//     readdata          registered read data, valid the cycle after read
//     irq               done & ie, registered
module avalon_muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic [WIDTH-1:0] writedata,
   input  logic             write,
   input  logic             read,
   input  logic             chipselect,
   output logic [WIDTH-1:0] readdata,
   output logic             irq
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

   state_t state, state_nxt;

   // bus-visible registers
   logic [WIDTH-1:0] opa, opb;
   logic             ctrl_op, ctrl_sgn, ctrl_ie;
   logic             done, dz;
   logic [WIDTH-1:0] res_lo, res_hi;

   // snapshot of the running operation
   logic [WIDTH-1:0] run_a, run_b;
   logic             run_op, run_sgn;

   // iteration datapath: hi:lo is the product or remainder:quotient
   logic [WIDTH-1:0] bmag, hi, lo;
   logic             neg_q, neg_r;
   logic [CW-1:0]    cnt;

   logic             ctrl_wr, stat_wr, start, busy;
   logic             done_nxt, dz_nxt, ie_nxt;
   logic [WIDTH:0]   sum, sh, diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] fix_lo, fix_hi;

   assign busy = (state != IDLE);

   // ---------------- control decode / flags ----------------
   always_comb begin
      ctrl_wr  = chipselect & write & (address == 3'd2);
      stat_wr  = chipselect & write & (address == 3'd3);
      // CTRL writes are dropped entirely while an op is running
      start    = ctrl_wr & writedata[0] & (state == IDLE);
      ie_nxt   = (ctrl_wr & (state == IDLE)) ? writedata[3] : ctrl_ie;

      done_nxt = done;
      dz_nxt   = dz;
      if (stat_wr & writedata[1]) begin
         done_nxt = 1'b0;
         dz_nxt   = 1'b0;
      end
      if (state == FIX) begin
         done_nxt = 1'b1;
         dz_nxt   = run_op & (run_b == '0);
      end
      if (start) begin
         done_nxt = 1'b0;
         dz_nxt   = 1'b0;
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = PREP;
         PREP:    state_nxt = RUN;
         RUN:     if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- step arithmetic ----------------
   always_comb begin
      // multiply: add B when the current multiplier bit is set, then shift right
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, bmag} : '0);
      // divide: shift in next dividend bit, trial subtract; diff[WIDTH] is borrow
      sh   = {hi, lo[WIDTH-1]};
      diff = sh - {1'b0, bmag};
      prod = {hi, lo};

      fix_lo = '0;
      fix_hi = '0;
      if (run_op) begin
         if (run_b == '0) begin
            fix_lo = '1;
            fix_hi = run_a;
         end else begin
            fix_lo = neg_q ? -lo : lo;
            fix_hi = neg_r ? -hi : hi;
         end
      end else begin
         {fix_hi, fix_lo} = neg_q ? -prod : prod;
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opa      <= '0;
         opb      <= '0;
         ctrl_op  <= 1'b0;
         ctrl_sgn <= 1'b0;
         ctrl_ie  <= 1'b0;
         done     <= 1'b0;
         dz       <= 1'b0;
         irq      <= 1'b0;
         res_lo   <= '0;
         res_hi   <= '0;
         run_a    <= '0;
         run_b    <= '0;
         run_op   <= 1'b0;
         run_sgn  <= 1'b0;
         bmag     <= '0;
         hi       <= '0;
         lo       <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         cnt      <= '0;
         readdata <= '0;
      end else begin
         // OPA/OPB are plain storage; the running op uses its snapshot
         if (chipselect & write & (address == 3'd0)) opa <= writedata;
         if (chipselect & write & (address == 3'd1)) opb <= writedata;
         if (ctrl_wr & (state == IDLE)) begin
            ctrl_op  <= writedata[1];
            ctrl_sgn <= writedata[2];
         end
         ctrl_ie <= ie_nxt;
         done    <= done_nxt;
         dz      <= dz_nxt;
         irq     <= done_nxt & ie_nxt;

         if (start) begin
            run_a   <= opa;
            run_b   <= opb;
            run_op  <= writedata[1];
            run_sgn <= writedata[2];
         end

         case (state)
            PREP: begin
               lo    <= (run_sgn & run_a[WIDTH-1]) ? -run_a : run_a;
               bmag  <= (run_sgn & run_b[WIDTH-1]) ? -run_b : run_b;
               hi    <= '0;
               cnt   <= '0;
               neg_q <= run_sgn & (run_a[WIDTH-1] ^ run_b[WIDTH-1]);
               neg_r <= run_sgn & run_a[WIDTH-1];
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (!run_op) begin
                  hi <= sum[WIDTH:1];
                  lo <= {sum[0], lo[WIDTH-1:1]};
               end else if (!diff[WIDTH]) begin
                  hi <= diff[WIDTH-1:0];
                  lo <= {lo[WIDTH-2:0], 1'b1};
               end else begin
                  hi <= sh[WIDTH-1:0];
                  lo <= {lo[WIDTH-2:0], 1'b0};
               end
            end
            FIX: begin
               res_lo <= fix_lo;
               res_hi <= fix_hi;
            end
            default: ;
         endcase

         if (chipselect & read) begin
            case (address)
               3'd0:    readdata <= opa;
               3'd1:    readdata <= opb;
               3'd2:    readdata <= WIDTH'({ctrl_ie, ctrl_sgn, ctrl_op, 1'b0});
               3'd3:    readdata <= WIDTH'({dz, done, busy});
               3'd4:    readdata <= res_lo;
               3'd5:    readdata <= res_hi;
               default: readdata <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_avalon_muldiv_seq.sv
// Directed bench for avalon_muldiv_seq (WIDTH=32).
module tb_avalon_muldiv_seq;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic [2:0]   address;
   logic [W-1:0] writedata, readdata;
   logic         write, read, chipselect, irq;

   int checks = 0;
   int errors = 0;

   avalon_muldiv_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .address(address), .writedata(writedata),
      .write(write), .read(read), .chipselect(chipselect),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [W-1:0] d);
      @(negedge clk);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(posedge clk); #1;
      chipselect = 1'b0; read = 1'b0;
      d = readdata;
   endtask

   task automatic wait_done(input string tag);
      logic [W-1:0] s;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         rd(3'd3, s);
         if (s[1]) begin ok = 1'b1; break; end
      end
      chk({tag, "_done"}, W'(ok), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ctrl, input logic [W-1:0] exp_lo,
                         input logic [W-1:0] exp_hi);
      logic [W-1:0] v;
      wr(3'd0, a);
      wr(3'd1, b);
      wr(3'd2, ctrl);
      wait_done(tag);
      rd(3'd4, v); chk({tag, "_lo"}, v, exp_lo);
      rd(3'd5, v); chk({tag, "_hi"}, v, exp_hi);
   endtask

   initial begin
      logic [W-1:0] v;
      reset = 1'b1; address = '0; writedata = '0;
      write = 1'b0; read = 1'b0; chipselect = 1'b0;
      #23 reset = 1'b0;

      // reset state
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_irq", W'(irq), 32'h0);
      rd(3'd3, v); chk("rst_stat", v, 32'h0);
      rd(3'd4, v); chk("rst_res_lo", v, 32'h0);
      rd(3'd2, v); chk("rst_ctrl", v, 32'h0);
      // RO register writes are ignored; unmapped address reads 0
      wr(3'd4, 32'h1234_5678);
      rd(3'd4, v); chk("ro_write", v, 32'h0);
      rd(3'd6, v); chk("addr6", v, 32'h0);

      // 1: unsigned mul, exact latency, irq with ie
      wr(3'd0, 32'hFFFF_FFFF);
      wr(3'd1, 32'hFFFF_FFFF);
      wr(3'd2, 32'h9);               // edge 1: start, mul, unsigned, ie
      repeat (33) @(posedge clk);    // edge 34
      #1 chk("lat_irq_e34", W'(irq), 32'h0);
      rd(3'd3, v);                   // captured at edge 35, pre-edge state
      chk("lat_stat_e35", v, 32'h1);
      chk("lat_irq_e35", W'(irq), 32'h1);
      rd(3'd3, v); chk("lat_stat_e36", v, 32'h2);
      rd(3'd4, v); chk("umul_lo", v, 32'h0000_0001);
      rd(3'd5, v); chk("umul_hi", v, 32'hFFFF_FFFE);
      rd(3'd2, v); chk("ctrl_rd", v, 32'h8);

      // 2: signed mul and signed div
      run_op("smul", 32'hFFFF_FFFD, 32'd7, 32'h5, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
      run_op("sdiv", 32'hFFFF_FFF9, 32'd2, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_op("udiv", 32'd100, 32'd7, 32'h3, 32'd14, 32'd2);

      // 3: divide by zero, then clear flags
      run_op("dz", 32'd100, 32'd0, 32'h3, 32'hFFFF_FFFF, 32'h0000_0064);
      rd(3'd3, v); chk("dz_stat", v, 32'h6);
      wr(3'd3, 32'h2);
      rd(3'd3, v); chk("dz_clear", v, 32'h0);

      // 4: signed MIN / -1
      run_op("minneg1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h7, 32'h8000_0000, 32'h0);
      rd(3'd3, v); chk("minneg1_stat", v, 32'h2);

      // 5: second start and OPA write while busy
      wr(3'd0, 32'd5);
      wr(3'd1, 32'd6);
      wr(3'd2, 32'h9);               // edge 1
      repeat (3) @(posedge clk);
      wr(3'd2, 32'h7);               // edge 5: ignored start
      wr(3'd0, 32'd11);
      wait_done("busy");
      rd(3'd4, v); chk("busy_lo", v, 32'd30);
      rd(3'd5, v); chk("busy_hi", v, 32'd0);
      rd(3'd2, v); chk("busy_ctrl", v, 32'h8);
      rd(3'd0, v); chk("busy_opa", v, 32'd11);
      chk("busy_irq", W'(irq), 32'h1);
      wr(3'd3, 32'h2);
      #1 chk("busy_irq_clr", W'(irq), 32'h0);
      repeat (45) @(posedge clk);
      rd(3'd3, v); chk("busy_one_done", v, 32'h0);

      // 6: reset mid-run, then normal completion
      wr(3'd0, 32'd9);
      wr(3'd1, 32'd9);
      wr(3'd2, 32'h9);               // edge 1
      repeat (11) @(posedge clk);    // edge 12: RUN cycle 10
      #2 reset = 1'b1;
      #10 reset = 1'b0;
      chk("mid_rst_irq", W'(irq), 32'h0);
      chk("mid_rst_readdata", readdata, 32'h0);
      rd(3'd3, v); chk("mid_rst_stat", v, 32'h0);
      rd(3'd4, v); chk("mid_rst_lo", v, 32'h0);
      rd(3'd5, v); chk("mid_rst_hi", v, 32'h0);
      repeat (40) @(posedge clk);
      rd(3'd3, v); chk("mid_rst_no_done", v, 32'h0);
      run_op("after_rst", 32'd100, 32'd7, 32'h3, 32'd14, 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
